uwasic_onboarding_bernice_lam: RTL and testbench

//  Tiny Tapeout user-project top: SPI-write-only register file (mode 0) driving
//  16 output lines, each selectable as static level or shared PWM waveform.
//  ui_in carries the SPI pins; uo_out/uio_out carry the 16 driven outputs.

---
 rtl/uwasic_onboarding_bernice_lam_pkg.sv | 48 ++++
 rtl/uwasic_onboarding_bernice_lam_pwm_peripheral.sv | 65 ++++++
 rtl/uwasic_onboarding_bernice_lam.sv | 200 ++++++++++++++++++++
 tb/tb_uwasic_onboarding_bernice_lam.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uwasic_onboarding_bernice_lam_pkg.sv
// ----------------------------------------------------------------------------
// uwasic_onboarding_bernice_lam_pkg
//
// Shared definitions for the SPI-programmed PWM output block:
//   - register address map of the write-only register file
//   - PWM prescaler divide ratio and derived counter widths
//   - SPI frame layout (R/W flag, 7-bit address, 8-bit data, MSB first)
//   - helper deciding whether a received frame is a committable write
// ----------------------------------------------------------------------------
package uwasic_onboarding_bernice_lam_pkg;

    // clk cycles per PWM counter tick: 10 MHz / 13 / 256 gives about 3.0 kHz
    localparam int CLK_DIV    = 13;
    localparam int NUM_REGS   = 5;
    localparam int FRAME_BITS = 16;

    localparam int PRESCALE_W = $clog2(CLK_DIV);
    // The bit counter must be able to hold FRAME_BITS itself (saturation value)
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_OUT_EN_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_OUT_EN_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_LAST      = ADDR_W'(NUM_REGS - 1);

    // Layout of the 16-bit frame as it sits in the shift register once
    // complete: first bit received ends up in the MSB.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    // A frame is only acted on when exactly FRAME_BITS bits arrived, it is a
    // write, and it targets an implemented register. Anything else is dropped.
    function automatic logic frame_commits(input spi_frame_t frame,
                                           input logic [BIT_CNT_W-1:0] bit_cnt);
        return (bit_cnt == BIT_CNT_W'(FRAME_BITS)) &&
               frame.write &&
               (frame.addr <= ADDR_LAST);
    endfunction

endpackage

// File: rtl/uwasic_onboarding_bernice_lam_pwm_peripheral.sv
// ----------------------------------------------------------------------------
// uwasic_onboarding_bernice_lam_pwm_peripheral
//
// Generates one shared PWM waveform and muxes it onto 16 output lines.
//
// Ports:
//   clk     in   1   system clock
//   rst_n   in   1   asynchronous active-low reset
//   out_en  in  16   per-line enable; 0 forces the line low
//   pwm_en  in  16   per-line PWM select; 0 gives a static high when enabled
//   duty    in   8   shared duty cycle, 0x00 = always low, 0xFF = always high
//   out     out 16   registered output lines
// ----------------------------------------------------------------------------
module uwasic_onboarding_bernice_lam_pwm_peripheral
    import uwasic_onboarding_bernice_lam_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] out_en,
    input  logic [15:0] pwm_en,
    input  logic [7:0]  duty,
    output logic [15:0] out
);

    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_d;
    logic [7:0]            pwm_cnt_q;
    logic [7:0]            pwm_cnt_d;
    logic [15:0]           out_q;
    logic [15:0]           out_d;

    logic                  prescale_wrap;
    logic                  pwm_sig;

    // Prescaler runs 0..CLK_DIV-1; each wrap advances the 8-bit period
    // counter, which rolls over naturally from 255 to 0.
    always_comb begin
        prescale_wrap = (prescale_q == PRESCALE_W'(CLK_DIV - 1));
        prescale_d    = prescale_wrap ? '0 : prescale_q + PRESCALE_W'(1);
        pwm_cnt_d     = prescale_wrap ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    // A plain compare can never be high for all 256 counts, so 0xFF is
    // special-cased to a solid high level. Duty is used directly, so a new
    // value takes effect mid-period.
    always_comb begin
        pwm_sig = (duty == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty);
        out_d   = out_en & (~pwm_en | {16{pwm_sig}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= '0;
            pwm_cnt_q  <= '0;
            out_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            pwm_cnt_q  <= pwm_cnt_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/uwasic_onboarding_bernice_lam.sv
// ----------------------------------------------------------------------------
// uwasic_onboarding_bernice_lam
//
// Tiny Tapeout user-project top. A write-only SPI (mode 0) register file
// configures 16 output lines, each either a static level or a shared PWM
// waveform.
//
// Ports:
//   clk      in   1   system clock (nominal 10 MHz), single clock domain
//   rst_n    in   1   asynchronous active-low reset
//   ena      in   1   harness design select, ignored
//   ui_in    in   8   [0]=SCLK [1]=COPI [2]=nCS, [7:3] unused
//   uio_in   in   8   unused
//   uo_out   out  8   output channels 7..0
//   uio_out  out  8   output channels 15..8
//   uio_oe   out  8   constant 8'hFF, all bidirectional pins driven
// ----------------------------------------------------------------------------
module uwasic_onboarding_bernice_lam
    import uwasic_onboarding_bernice_lam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ------------------------------------------------------------------
    // SPI pin synchronizers
    // ------------------------------------------------------------------
    logic [2:0] sclk_sync_q;
    logic [2:0] sclk_sync_d;
    logic [1:0] copi_sync_q;
    logic [1:0] copi_sync_d;
    logic [2:0] ncs_sync_q;
    logic [2:0] ncs_sync_d;

    logic       sclk_rise;
    logic       ncs_fall;
    logic       ncs_rise;
    logic       ncs_low;
    logic       copi_bit;

    // Bits [1:0] are the two-flop synchronizer; bit [2] holds the previous
    // synchronized value so edges can be detected without metastability risk.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], ui_in[0]};
        copi_sync_d = {copi_sync_q[0], ui_in[1]};
        ncs_sync_d  = {ncs_sync_q[1:0], ui_in[2]};
    end

    always_comb begin
        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
        ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];
        ncs_low   = ~ncs_sync_q[1];
        copi_bit  = copi_sync_q[1];
    end

    // nCS synchronizer resets to the idle-high level so leaving reset with
    // the bus idle does not look like a chip-select edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame shift register and bit counter
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    spi_frame_t            rx_frame;

    assign rx_frame = spi_frame_t'(shift_q);

    // Once FRAME_BITS bits are in, further SCLK edges are ignored so the
    // first 16 bits of an over-long frame are what gets committed.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (ncs_fall) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (ncs_low && sclk_rise &&
                     (bit_cnt_q != BIT_CNT_W'(FRAME_BITS))) begin
            shift_d   = {shift_q[FRAME_BITS-2:0], copi_bit};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Commit stage
    // ------------------------------------------------------------------
    logic       commit_q;
    logic       commit_d;
    spi_frame_t commit_frame_q;
    spi_frame_t commit_frame_d;

    // The frame is captured at the nCS rising edge and written one clock
    // later; holding a private copy keeps the write safe even if a new frame
    // starts clearing the shift register immediately.
    always_comb begin
        commit_d       = ncs_rise && frame_commits(rx_frame, bit_cnt_q);
        commit_frame_d = ncs_rise ? rx_frame : commit_frame_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q       <= 1'b0;
            commit_frame_q <= '0;
        end else begin
            commit_q       <= commit_d;
            commit_frame_q <= commit_frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [15:0] out_en_q;
    logic [15:0] out_en_d;
    logic [15:0] pwm_en_q;
    logic [15:0] pwm_en_d;
    logic [7:0]  duty_q;
    logic [7:0]  duty_d;

    always_comb begin
        out_en_d = out_en_q;
        pwm_en_d = pwm_en_q;
        duty_d   = duty_q;
        if (commit_q) begin
            case (commit_frame_q.addr)
                ADDR_OUT_EN_LO: out_en_d[7:0]  = commit_frame_q.data;
                ADDR_OUT_EN_HI: out_en_d[15:8] = commit_frame_q.data;
                ADDR_PWM_EN_LO: pwm_en_d[7:0]  = commit_frame_q.data;
                ADDR_PWM_EN_HI: pwm_en_d[15:8] = commit_frame_q.data;
                ADDR_DUTY:      duty_d         = commit_frame_q.data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q <= '0;
            pwm_en_q <= '0;
            duty_q   <= '0;
        end else begin
            out_en_q <= out_en_d;
            pwm_en_q <= pwm_en_d;
            duty_q   <= duty_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM generation and output mapping
    // ------------------------------------------------------------------
    logic [15:0] pwm_out;

    uwasic_onboarding_bernice_lam_pwm_peripheral u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .out_en (out_en_q),
        .pwm_en (pwm_en_q),
        .duty   (duty_q),
        .out    (pwm_out)
    );

    assign uo_out  = pwm_out[7:0];
    assign uio_out = pwm_out[15:8];
    assign uio_oe  = 8'hFF;

    // Harness pins this design does not use are gathered here so they are
    // visibly accounted for.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_bernice_lam.sv
// ----------------------------------------------------------------------------
// tb_uwasic_onboarding_bernice_lam
//
// Self-checking bench: SPI frames from a vector table, expected pin levels
// queued per frame and compared once the write has had time to land, plus
// hand-written PWM timing and reset-mid-frame sequences.
// ----------------------------------------------------------------------------
module tb_uwasic_onboarding_bernice_lam;

    localparam int PWM_PERIOD = 13 * 256;
    localparam int SCLK_HALF  = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    uwasic_onboarding_bernice_lam dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [7:0]  exp_uo;
        logic [7:0]  exp_uio;
        string       name;
    } vec_t;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      name;
    } exp_t;

    localparam int NUM_VECS = 13;
    vec_t vecs [NUM_VECS];
    exp_t sb_q [$];

    int n_compared;
    int n_mismatched;

    // Wait n clocks and step just past the edge so sampling and driving
    // stay away from the active edge.
    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One SPI mode-0 frame, MSB first; bits beyond 16 are sent as ones.
    task automatic applyStimulus(input logic [15:0] word, input int nbits);
        logic [15:0] sh;
        sh = word;
        ncs = 1'b0;
        waitClocks(SCLK_HALF);
        for (int i = 0; i < nbits; i++) begin
            copi = sh[15];
            sh   = {sh[14:0], 1'b1};
            waitClocks(SCLK_HALF);
            sclk = 1'b1;
            waitClocks(SCLK_HALF);
            sclk = 1'b0;
        end
        waitClocks(SCLK_HALF);
        ncs  = 1'b1;
        copi = 1'b0;
        waitClocks(SCLK_HALF);
    endtask

    task automatic pushExpected(input logic [7:0] uo, input logic [7:0] uio, input string name);
        exp_t e;
        e.uo   = uo;
        e.uio  = uio;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic checkScoreboard();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb_q.pop_front();
            checkOutput({e.name, "_uo"},  int'(uo_out),  int'(e.uo));
            checkOutput({e.name, "_uio"}, int'(uio_out), int'(e.uio));
        end
    endtask

    task automatic writeAndCheck(input logic [15:0] word, input int nbits,
                                 input logic [7:0] uo, input logic [7:0] uio,
                                 input string name);
        applyStimulus(word, nbits);
        pushExpected(uo, uio, name);
        waitClocks(10);
        checkScoreboard();
    endtask

    // Returns number of negedges waited until uo_out[0] rises, -1 on timeout.
    task automatic waitRise(output int waited);
        logic prev;
        waited = -1;
        @(negedge clk);
        prev = uo_out[0];
        for (int i = 1; i <= PWM_PERIOD + 200; i++) begin
            @(negedge clk);
            if (uo_out[0] && !prev) begin
                waited = i;
                break;
            end
            prev = uo_out[0];
        end
    endtask

    // Starting right after a rise: counts negedges to the next rise and the
    // high samples in between (the first high sample included). Also counts
    // any activity on uo_out[7:1], which must stay low.
    task automatic measurePeriod(output int period, output int highs, output int stray);
        logic prev;
        period = -1;
        highs  = 1;
        stray  = 0;
        prev   = 1'b1;
        for (int i = 1; i <= 2 * PWM_PERIOD; i++) begin
            @(negedge clk);
            if (uo_out[7:1] != 7'd0) stray++;
            if (uo_out[0] && !prev) begin
                period = i;
                break;
            end
            if (uo_out[0]) highs++;
            prev = uo_out[0];
        end
    endtask

    task automatic measureWindow(input int nsamples, output int highs);
        highs = 0;
        for (int i = 0; i < nsamples; i++) begin
            @(negedge clk);
            if (uo_out[0]) highs++;
        end
    endtask

    task automatic checkPwm(input logic [7:0] duty, input int exp_highs, input string name);
        int waited;
        int period;
        int highs;
        int stray;
        applyStimulus({1'b1, 7'h04, duty}, 16);
        waitClocks(10);
        waitRise(waited);
        if (waited < 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_rise: got timeout, expected rising edge", name);
        end else begin
            measurePeriod(period, highs, stray);
            checkOutput({name, "_period"}, period, PWM_PERIOD);
            checkOutput({name, "_high"},   highs,  exp_highs);
            checkOutput({name, "_others"}, stray,  0);
        end
    endtask

    initial begin
        int highs;
        n_compared   = 0;
        n_mismatched = 0;

        vecs[0]  = '{16'h80F0, 16, 8'hF0, 8'h00, "wr_oe_lo"};
        vecs[1]  = '{16'h81CC, 16, 8'hF0, 8'hCC, "wr_oe_hi"};
        vecs[2]  = '{16'hB0AA, 16, 8'hF0, 8'hCC, "addr_30"};
        vecs[3]  = '{16'h00FF, 16, 8'hF0, 8'hCC, "read_frame"};
        vecs[4]  = '{16'h8512, 16, 8'hF0, 8'hCC, "addr_05"};
        vecs[5]  = '{16'h800F,  8, 8'hF0, 8'hCC, "partial_8"};
        vecs[6]  = '{16'h8055, 16, 8'h55, 8'hCC, "full_after_partial"};
        vecs[7]  = '{16'h803C, 17, 8'h3C, 8'hCC, "extra_bit"};
        vecs[8]  = '{16'h82FF, 15, 8'h3C, 8'hCC, "short_15"};
        vecs[9]  = '{16'h8480, 16, 8'h3C, 8'hCC, "duty_static"};
        vecs[10] = '{16'h81FF, 16, 8'h3C, 8'hFF, "oe_hi_all"};
        vecs[11] = '{16'h8300, 16, 8'h3C, 8'hFF, "pwm_hi_zero"};
        vecs[12] = '{16'h8001, 16, 8'h01, 8'hFF, "oe_lo_bit0"};

        rst_n  = 1'b0;
        ena    = 1'b1;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        uio_in = 8'h00;
        waitClocks(5);
        checkOutput("reset_uo",     int'(uo_out),  8'h00);
        checkOutput("reset_uio",    int'(uio_out), 8'h00);
        checkOutput("reset_uio_oe", int'(uio_oe),  8'hFF);
        rst_n = 1'b1;
        waitClocks(5);

        for (int v = 0; v < NUM_VECS; v++) begin
            writeAndCheck(vecs[v].word, vecs[v].nbits, vecs[v].exp_uo,
                          vecs[v].exp_uio, vecs[v].name);
        end

        // Channel 0 onto PWM; duty sweeps through its special values.
        applyStimulus(16'h8201, 16);
        checkPwm(8'h80, 1664, "duty_80");
        checkOutput("pwm_uio_static", int'(uio_out), 8'hFF);

        applyStimulus(16'h8400, 16);
        waitClocks(10);
        measureWindow(2 * PWM_PERIOD, highs);
        checkOutput("duty_00_high", highs, 0);

        applyStimulus(16'h84FF, 16);
        waitClocks(10);
        measureWindow(2 * PWM_PERIOD, highs);
        checkOutput("duty_FF_high", highs, 2 * PWM_PERIOD);

        checkPwm(8'h01, 13, "duty_01");

        // Reset in the middle of a frame: outputs drop at once, nothing from
        // the interrupted frame lands, and all registers are back to zero.
        ncs = 1'b0;
        waitClocks(SCLK_HALF);
        for (int i = 0; i < 5; i++) begin
            copi = 1'b1;
            waitClocks(SCLK_HALF);
            sclk = 1'b1;
            waitClocks(SCLK_HALF);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midframe_rst_uio", int'(uio_out), 8'h00);
        checkOutput("midframe_rst_uo",  int'(uo_out),  8'h00);
        waitClocks(3);
        ncs  = 1'b1;
        copi = 1'b0;
        waitClocks(2);
        rst_n = 1'b1;
        waitClocks(20);
        checkOutput("post_rst_uo",  int'(uo_out),  8'h00);
        checkOutput("post_rst_uio", int'(uio_out), 8'h00);

        writeAndCheck(16'h81FF, 16, 8'h00, 8'hFF, "post_rst_oe_hi");
        writeAndCheck(16'h80FF, 16, 8'hFF, 8'hFF, "post_rst_oe_lo");
        writeAndCheck(16'h82FF, 16, 8'h00, 8'hFF, "post_rst_duty0");
        writeAndCheck(16'h84FF, 16, 8'hFF, 8'hFF, "post_rst_dutyFF");

        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
